// File: rtl/pulse_event_arbiter_if.sv
// Event channel between the pulse arbiter and its consumer.
// Latency: none, wires only.
// Backpressure: evt_ready from the consumer holds the offered event in place.
//
// Signals:
//   evt_valid  producer -> consumer  an event index is being offered
//   evt_idx    producer -> consumer  channel number of the offered event
//   evt_ready  consumer -> producer  consumer takes the event this cycle
interface pulse_event_arbiter_if #(
    parameter int IDX_W = 2
) ();
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_ready;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/pulse_event_arbiter.sv
// Edge-to-event converter: synchronises level inputs, latches edges as pending
//   requests, and serialises them round-robin onto one valid/ready channel.
// Latency: SYNC_STAGES+2 clocks from first sync capture to evt_valid; max one event per 2 clocks.
// Backpressure: evt_valid/evt_idx hold until evt_ready; further edges on a pending
//   channel coalesce into the single outstanding request.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset, clears every register
//   lvl_in    asynchronous level inputs, one per channel
//   evt       event channel (master side: evt_valid, evt_idx out; evt_ready in)
//   pending   registered per-channel pending flags
//   busy      any pending bit set or an event being offered
//
// Optional build macro PULSE_ARB_DROP_FLAG_EN adds:
//   clr_drop  clears all dropped flags
//   dropped   sticky per-channel flag: an edge was merged into an already pending request
module pulse_event_arbiter #(
    parameter int    NUM_CH      = 4,
    parameter int    IDX_W       = 2,
    parameter string MODE        = "RISING",
    parameter int    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     lvl_in,
    pulse_event_arbiter_if.master evt,
    output logic [NUM_CH-1:0]     pending,
    output logic                  busy
`ifdef PULSE_ARB_DROP_FLAG_EN
    ,
    input  logic                  clr_drop,
    output logic [NUM_CH-1:0]     dropped
`endif
);

    // Arm counter runs 0..ARM_MAX and then sticks. ARM_MAX is one past the
    // point where a level held through reset reaches prev, so the spurious
    // edge seen while the chain fills up is never latched.
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and previous-value copy
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= lvl_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            // prev keeps tracking while arming so that the first armed
            // cycle compares against a settled value.
            prev_q <= sync_s;
        end
    end

    // ------------------------------------------------------------------
    // Arm counter
    // ------------------------------------------------------------------
    logic [ARM_W-1:0] arm_q;
    logic             armed;

    assign armed = (arm_q == ARM_W'(ARM_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= '0;
        end else if (!armed) begin
            arm_q <= arm_q + ARM_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Edge detect
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] raw_edge;
    logic [NUM_CH-1:0] edge_det;

    generate
        if (MODE == "BOTH") begin : g_edge_both
            assign raw_edge = sync_s ^ prev_q;
        end else if (MODE == "FALLING") begin : g_edge_fall
            assign raw_edge = ~sync_s & prev_q;
        end else begin : g_edge_rise
            assign raw_edge = sync_s & ~prev_q;
        end
    endgenerate

    assign edge_det = armed ? raw_edge : '0;

    // ------------------------------------------------------------------
    // Pending flags
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] clr;
    logic              valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic              accept;

    assign accept = valid_q & evt.evt_ready;
    assign clr    = accept ? (NUM_CH'(1) << idx_q) : '0;

    // OR-ing the edge after the clear keeps an event that lands in the same
    // cycle its channel is being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | edge_det;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin selection: rotate pending so the pointer lands on bit 0,
    // take the lowest set bit, then rotate the offset back.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  ptr_q;
    logic [NUM_CH-1:0] rot;
    logic [IDX_W-1:0]  pick_off;
    logic [IDX_W:0]    pick_sum;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;

    always_comb begin
        rot      = NUM_CH'({pending_q, pending_q} >> ptr_q);
        pick_vld = |rot;
        pick_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_off = IDX_W'(j);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W+1)'(NUM_CH)) begin
            pick_sum = pick_sum - (IDX_W+1)'(NUM_CH);
        end
        pick_idx = pick_sum[IDX_W-1:0];
    end

    // ------------------------------------------------------------------
    // Offer FSM. The return to IDLE after every accept gives the pending
    // register a cycle to drop the served bit before the next pick.
    // ------------------------------------------------------------------
    state_t state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt.evt_ready) begin
                        ptr_q   <= (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + IDX_W'(1);
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_idx   = idx_q;
    assign pending       = pending_q;
    assign busy          = (|pending_q) | valid_q;

`ifdef PULSE_ARB_DROP_FLAG_EN
    // ------------------------------------------------------------------
    // Coalesced-event flags: set beats clear when both hit together.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] dropped_q;
    logic [NUM_CH-1:0] drop_set;

    assign drop_set = edge_det & pending_q & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= (dropped_q & ~{NUM_CH{clr_drop}}) | drop_set;
        end
    end

    assign dropped = dropped_q;
`endif

endmodule

// File: doc/pulse_event_arbiter.md
Name: pulse_event_arbiter

Overview:
- Converts NUM_CH asynchronous level inputs (panel status lines, button/strobe levels) into edge events.
- Latches each event as a pending request and serialises the requests onto one valid/ready event channel using round-robin.
- Sits between raw board-level status signals and the refresh sequencer, which consumes one event index at a time.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- IDX_W, 2, width of evt_idx; must satisfy 2**IDX_W >= NUM_CH.
- MODE, "RISING", edge type that creates an event on every channel: "RISING", "FALLING" or "BOTH" (either transition).
- SYNC_STAGES, 2, depth of the per-channel input synchroniser (2..4).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- lvl_in  input  NUM_CH  asynchronous level inputs, one bit per channel.
- evt_valid  output  1  event offered to the consumer.
- evt_idx  output  IDX_W  channel number of the offered event.
- evt_ready  input  1  consumer accepts the event.
- pending  output  NUM_CH  registered per-channel pending flags.
- busy  output  1  high when any pending bit is set or evt_valid is high.

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n), polarity and synchronicity fixed. Asserting rst_n low clears, immediately and at any time including mid-handshake:
  - sync chains and prev copies to 0;
  - pending to 0;
  - arm counter to 0;
  - FSM to IDLE, evt_valid 0, evt_idx 0, round-robin pointer 0, busy 0.
- Synchroniser: SYNC_STAGES flops per channel; the output is s[i]. prev[i] <= s[i] every cycle.
- Arm counter:
  - After reset release it counts 0..SYNC_STAGES+1, then saturates.
  - Edges are ignored until it saturates, so a line held high through reset creates no event.
  - prev keeps tracking during arming.
- Edge detect (combinational from s and prev):
  - RISING: s & ~prev.
  - FALLING: ~s & prev.
  - BOTH: s ^ prev.
- Pending: pending[i] <= (pending[i] & ~clr[i]) | edge[i].
  - clr[i] is high in the cycle where evt_valid & evt_ready and evt_idx==i.
  - Edge and clear on the same channel in the same cycle: pending stays 1, because the new event is kept.
  - Edge while pending is already 1: events coalesce into one; nothing is queued twice.
- FSM, two states:
  - IDLE: if pending != 0, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_CH. Register evt_idx, set evt_valid=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: hold evt_valid=1 with evt_idx stable until evt_ready.
  - On evt_ready: clear pending[evt_idx]; ptr <= (evt_idx==NUM_CH-1) ? 0 : evt_idx+1; evt_valid <= 0; go to IDLE.
  - evt_ready while in IDLE is ignored.
- Throughput: at most one event per 2 cycles.
- Latency, once armed: evt_valid is high after SYNC_STAGES+2 rising edges, counted from the edge whose first sync flop captures the new level, with FSM in IDLE.
- busy = (|pending) | evt_valid, registered-source only.

Optional Feature:
- Macro: PULSE_ARB_DROP_FLAG_EN.
- Defined:
  - Adds input clr_drop (1 bit) and output dropped (NUM_CH bits).
  - dropped[i] is set when edge[i] arrives while pending[i]=1 and pending[i] is not being cleared in that cycle, i.e. a coalesced event.
  - dropped[i] is sticky until clr_drop=1, which clears all bits. If set and clear hit the same cycle, set wins.
  - Reset value is 0.
- Undefined: neither port exists and there is no extra logic. Coalescing behaviour is identical in both cases.

Test Plan:
- Reset with lvl_in=4'b0001 held high, release, wait 10 cycles -> evt_valid stays 0, pending=0 (arm suppression).
- MODE="RISING", armed, lvl_in[2] 0->1, evt_ready=1 -> evt_valid=1, evt_idx=2 after the 4th edge; pending[2] clears and evt_valid=0 one cycle after acceptance.
- Rising edges on ch0, ch1, ch3 in the same cycle, ptr=0, evt_ready tied 1 -> evt_idx order 0,1,3 at 2-cycle spacing; after wrap a new ch0 event follows ch3.
- Hold evt_ready=0 for 20 cycles in OFFER, toggle lvl_in[1] three times -> evt_idx stable at the original value; pending[1]=1 once; with PULSE_ARB_DROP_FLAG_EN, dropped[1]=1 until clr_drop.
- MODE="BOTH", lvl_in[0] 0->1->0 spaced 10 cycles, ready always 1 -> exactly two events, both evt_idx=0.
- Assert rst_n low during OFFER with pending=4'b1010 -> evt_valid, pending and busy are 0 immediately (asynchronously); no event appears after release.
